// File: rtl/cm0_rst_seq_pkg.sv
// Shared types, legal parameter minimums and sizing helper for the
// Cortex-M0 reset sequencer.
package cm0_rst_seq_pkg;

    // Sequencer states: held in reset, minimum-assertion hold,
    // staggered channel release, steady state.
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_t;

    // Smallest legal values of the timing parameters.
    localparam int MIN_SYNC_DEPTH = 2;
    localparam int MIN_MIN_ASSERT = 1;
    localparam int MIN_STAGGER    = 1;

    // Width of the shared down-counter, which must hold the larger of
    // the two reload values.
    function automatic int cnt_width(input int min_assert, input int stagger);
        int largest;
        largest = (min_assert > stagger) ? min_assert : stagger;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/cm0_rst_sync_chain.sv
// Reset deassertion synchroniser: a chain of async-cleared flops with the
// input tied high. Swapped for a library synchroniser cell at implementation.
module cm0_rst_sync_chain #(
    parameter int SYNC_DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic synced
);

    logic [SYNC_DEPTH-1:0] chain;

    // Shift ones in after reset; any reset pulse clears the whole chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign synced = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/cm0_rst_seq.sv
// Reset synchroniser and sequencer: asynchronous assertion, synchronised
// deassertion, minimum hold time and staggered per-channel release.
module cm0_rst_seq
    import cm0_rst_seq_pkg::*;
#(
    parameter int SYNC_DEPTH = 3,
    parameter int NUM_OUT    = 3,
    parameter int MIN_ASSERT = 4,
    parameter int STAGGER    = 4
) (
    input  logic               CLK,
    input  logic               RSTINn,
    input  logic               RSTREQ,
    input  logic               SE,
    input  logic               RSTBYPASS,
    output logic [NUM_OUT-1:0] RSTOUTn,
    output logic               RSTACTIVE
);

    localparam int CNT_W = cnt_width(MIN_ASSERT, STAGGER);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    if (SYNC_DEPTH < MIN_SYNC_DEPTH) begin : g_bad_sync_depth
        $error("cm0_rst_seq: SYNC_DEPTH must be at least 2");
    end
    if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
        $error("cm0_rst_seq: NUM_OUT must be in 1..16");
    end
    if (MIN_ASSERT < MIN_MIN_ASSERT) begin : g_bad_min_assert
        $error("cm0_rst_seq: MIN_ASSERT must be at least 1");
    end
    if (STAGGER < MIN_STAGGER) begin : g_bad_stagger
        $error("cm0_rst_seq: STAGGER must be at least 1");
    end

    logic               synced;
    logic               hold_req;
    logic               unused_se;
    rst_state_t         state_q;
    rst_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [NUM_OUT-1:0] out_q;
    logic [NUM_OUT-1:0] out_d;
    logic               active_q;

    // Scan enable only matters once DFT insertion stitches the chains.
    assign unused_se = SE;

    cm0_rst_sync_chain #(
        .SYNC_DEPTH(SYNC_DEPTH)
    ) u_sync_chain (
        .clk    (CLK),
        .rst_n  (RSTINn),
        .synced (synced)
    );

    // The request is ignored in bypass so the sequencer state does not
    // depend on scan-time activity on RSTREQ.
    assign hold_req = (RSTREQ & ~RSTBYPASS) | ~synced;

    // Next-state, counter and output computation. Leaving RESET counts as
    // the first hold cycle, because the synchroniser's final unsynchronised
    // sample is itself the last request cycle; with MIN_ASSERT of 1 that
    // means channel 0 is released straight away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;

        unique case (state_q)
            ST_RESET: begin
                out_d = '0;
                if (!hold_req) begin
                    if (MIN_ASSERT == 1) begin
                        out_d[0] = 1'b1;
                        if (NUM_OUT == 1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                            cnt_d   = CNT_W'(STAGGER);
                        end
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(MIN_ASSERT - 1);
                    end
                end
            end
            ST_HOLD: begin
                out_d = '0;
                if (cnt_q <= CNT_W'(1)) begin
                    out_d[0] = 1'b1;
                    if (NUM_OUT == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IDX_W'(1);
                        cnt_d   = CNT_W'(STAGGER);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            out_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = CNT_W'(STAGGER);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                out_d = '1;
            end
            default: begin
                state_d = ST_RESET;
                out_d   = '0;
            end
        endcase

        if (hold_req && state_q != ST_RESET) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(MIN_ASSERT);
            idx_d   = '0;
            out_d   = '0;
        end
    end

    // State register; outputs are flops so they cannot glitch in operation.
    always_ff @(posedge CLK or negedge RSTINn) begin
        if (!RSTINn) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            idx_q    <= '0;
            out_q    <= '0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            active_q <= ~&out_d;
        end
    end

    // DFT bypass hands the raw reset input straight to every channel.
    assign RSTOUTn   = RSTBYPASS ? {NUM_OUT{RSTINn}} : out_q;
    assign RSTACTIVE = RSTBYPASS ? ~RSTINn : active_q;

endmodule
